alu_instr_sequencer: RTL and testbench
======================================

Name: alu_instr_sequencer

Overview:
- Parametrised control sequencer that generates the per-state datapath control strobes the bus datapath needs to run one register-register ALU instruction.
- Sequence: mock fetch (T0–T2), operand staging (T3–T4), writeback (T5, plus T6 for HI/LO ops).
- Replaces hand-sequenced T-state strobing with a start/done FSM.
- Adds register-count/width generality, memory-read wait states, a two-cycle HI/LO writeback mode for MUL/DIV, and illegal-opcode reporting.

Parameters:
DATA_W, 32, bus and instruction width
NUM_REGS, 16, general registers; REG_AW = clog2(NUM_REGS)
OPCODE_W, 5, opcode field width

Ports:
clock  in  1  system clock, all state changes on rising edge
clear  in  1  synchronous active-low reset
start  in  1  begin one instruction; sampled only in IDLE
mem_ready  in  1  memory read data valid; T1 holds until high
ir  in  DATA_W  IR register contents
pc_out, inc_pc, mar_in, pc_in, read, mdr_in, mdr_out, ir_in, y_in, z_in, zlow_out, zhigh_out, hi_in, lo_in  out  1 each  datapath strobes
reg_in  out  NUM_REGS  one-hot register write enables
reg_out  out  NUM_REGS  one-hot register bus drivers
alu_op  out  OPCODE_W  ALU opcode
busy  out  1  high in every state except IDLE
done  out  1  one-cycle completion pulse
err  out  1  one-cycle illegal-opcode pulse, coincident with done

Behaviour:
- IR fields (MSB down):
  - opcode = ir[DATA_W-1 -: OPCODE_W]
  - ra = next REG_AW bits
  - rb = next REG_AW bits
  - rc = next REG_AW bits
  - At defaults: ra = ir[26:23], rb = ir[22:19], rc = ir[18:15].
- Outputs are decoded combinationally from the state register and ir only; each strobe is stable for the whole state cycle. Strobes not listed for a state are 0.
- States and strobes:
  - IDLE: all outputs 0. start=1 → T0.
  - T0: pc_out, mar_in, inc_pc, z_in. → T1.
  - T1: zlow_out, pc_in, read, mdr_in.
    - Stays in T1 while mem_ready=0, with read/mdr_in held.
    - pc_in is asserted only in the cycle where mem_ready=1, so PC increments exactly once.
    - mem_ready=1 → T2.
  - T2: mdr_out, ir_in. → T3. IR is loaded at the edge leaving T2.
  - T3: decode ir. Legality is determined here.
    - Legal opcodes: 3..11 (ALU), 15 (MUL), 16 (DIV).
    - Illegal opcode: done=1, err=1, no other strobes; → IDLE.
    - Legal opcode: reg_out[rb], y_in; → T4.
  - T4: reg_out[rc], alu_op=opcode, z_in. → T5.
  - T5:
    - ALU ops: zlow_out, reg_in[ra], done=1; → IDLE.
    - MUL/DIV: zlow_out, lo_in; → T6.
  - T6: zhigh_out, hi_in, done=1. → IDLE.
- alu_op is 0 in every state except T4.
- reg_in and reg_out are never multi-hot. Out-of-range indices cannot occur when NUM_REGS = 2^REG_AW.
- Latency from the start edge to done, with mem_ready tied high: 6 cycles for ALU ops, 7 for MUL/DIV. Each mem_ready=0 cycle adds one.
- start is ignored when not in IDLE. Minimum one IDLE cycle between instructions; start in the cycle after done is accepted.
- clear=0 at any rising edge → IDLE at that edge, all outputs 0 next cycle. Applies mid-instruction, including in T1 wait; no partial completion and no done pulse.
- Power-up state is undefined until the first clear=0 edge.

Test Plan:
- ADD R8,R6,R7: ir=0x1C338000, mem_ready=1, one start pulse → states T0..T5 on six consecutive cycles. Check:
  - T3: reg_out=0x0040, y_in=1.
  - T4: reg_out=0x0080, alu_op=5'b00011, z_in=1.
  - T5: reg_in=0x0100, zlow_out=1, done=1; err=0.
- Memory wait: same instruction with mem_ready low for the first 3 cycles of T1 → T1 lasts 4 cycles, read=1 throughout, pc_in=1 only in the 4th; done arrives 9 cycles after start.
- MUL R3,R4: ir=0x781A0000 → T5 has lo_in=1 and zlow_out=1 with reg_in=0; T6 has hi_in=1, zhigh_out=1, done=1; total 7 cycles.
- Illegal opcode: ir[31:27]=5'b11111 → in T3 done=1, err=1, reg_out=0, y_in=0; next cycle IDLE, busy=0.
- Reset mid-op: clear=0 for one edge while in T4 → next cycle IDLE, every output 0, no done. A fresh start then completes normally.
- Busy lockout: start held high through an entire ADD → second instruction's T0 begins exactly one cycle after the first done; start pulses during T0–T5 have no effect.

Source files
------------

// File: rtl/alu_instr_sequencer_if.sv
// -----------------------------------------------------------------------------
// alu_instr_sequencer_if
//
// Purpose: groups the start/done handshake, the IR contents and every datapath
// control strobe passed between an instruction issuer and alu_instr_sequencer.
//
// Handshake: the issuer (master) raises start; the sequencer (slave) accepts
// it only while busy=0. Once accepted, busy stays high until the cycle after
// done, and start is ignored throughout. done is a one-cycle pulse, and err
// pulses together with done when the opcode is illegal. mem_ready is the
// memory's data-valid flag and is only looked at during the fetch read.
//
// Signals:
//   start, mem_ready, ir            master -> slave
//   pc_out .. lo_in                 slave  -> datapath strobes
//   reg_in / reg_out                slave  -> one-hot register enables
//   alu_op                          slave  -> ALU opcode (nonzero only in T4)
//   busy, done, err                 slave  -> status
// -----------------------------------------------------------------------------
interface alu_instr_sequencer_if #(
   parameter int DATA_W   = 32,
   parameter int NUM_REGS = 16,
   parameter int OPCODE_W = 5
);
   logic                start;
   logic                mem_ready;
   logic [DATA_W-1:0]   ir;

   logic                pc_out;
   logic                inc_pc;
   logic                mar_in;
   logic                pc_in;
   logic                read;
   logic                mdr_in;
   logic                mdr_out;
   logic                ir_in;
   logic                y_in;
   logic                z_in;
   logic                zlow_out;
   logic                zhigh_out;
   logic                hi_in;
   logic                lo_in;
   logic [NUM_REGS-1:0] reg_in;
   logic [NUM_REGS-1:0] reg_out;
   logic [OPCODE_W-1:0] alu_op;
   logic                busy;
   logic                done;
   logic                err;

   modport master (
      output start, mem_ready, ir,
      input  pc_out, inc_pc, mar_in, pc_in, read, mdr_in, mdr_out, ir_in,
             y_in, z_in, zlow_out, zhigh_out, hi_in, lo_in,
             reg_in, reg_out, alu_op, busy, done, err
   );

   modport slave (
      input  start, mem_ready, ir,
      output pc_out, inc_pc, mar_in, pc_in, read, mdr_in, mdr_out, ir_in,
             y_in, z_in, zlow_out, zhigh_out, hi_in, lo_in,
             reg_in, reg_out, alu_op, busy, done, err
   );
endinterface

// File: rtl/alu_instr_sequencer.sv
// -----------------------------------------------------------------------------
// alu_instr_sequencer
//
// Purpose: start/done FSM that produces the per-T-state datapath strobes for
// one register-register ALU instruction: mock fetch (T0-T2), operand staging
// (T3-T4) and writeback (T5, plus T6 for the HI/LO half of MUL/DIV).
// Illegal opcodes end the instruction in T3 with done and err.
//
// Ports:
//   clock      system clock, all state changes on the rising edge
//   clear      synchronous active-low reset, returns the FSM to IDLE
//   bus        alu_instr_sequencer_if.slave (handshake, ir, strobes, status)
//   state_dbg  current FSM state (0=IDLE, 1..7 = T0..T6)
// -----------------------------------------------------------------------------
module alu_instr_sequencer #(
   parameter int DATA_W   = 32,
   parameter int NUM_REGS = 16,
   parameter int OPCODE_W = 5
) (
   input  logic                   clock,
   input  logic                   clear,
   alu_instr_sequencer_if.slave   bus,
   output logic [2:0]             state_dbg
);

   localparam int REG_AW = $clog2(NUM_REGS);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_T0   = 3'd1,
      S_T1   = 3'd2,
      S_T2   = 3'd3,
      S_T3   = 3'd4,
      S_T4   = 3'd5,
      S_T5   = 3'd6,
      S_T6   = 3'd7
   } state_t;

   state_t state;

   // IR fields, packed from the MSB down: opcode, ra, rb, rc.
   logic [OPCODE_W-1:0] opcode;
   logic [REG_AW-1:0]   ra;
   logic [REG_AW-1:0]   rb;
   logic [REG_AW-1:0]   rc;
   logic                op_legal;
   logic                op_hilo;
   logic                unused_ir_bits;

   assign opcode = bus.ir[DATA_W-1 -: OPCODE_W];
   assign ra     = bus.ir[DATA_W-1-OPCODE_W -: REG_AW];
   assign rb     = bus.ir[DATA_W-1-OPCODE_W-REG_AW -: REG_AW];
   assign rc     = bus.ir[DATA_W-1-OPCODE_W-2*REG_AW -: REG_AW];

   // Immediate/unused low IR bits carry no control meaning here.
   assign unused_ir_bits = ^bus.ir[DATA_W-1-OPCODE_W-3*REG_AW:0];

   // MUL (15) and DIV (16) write a 64-bit result, so they need the HI/LO pass.
   assign op_hilo  = (opcode == OPCODE_W'(15)) || (opcode == OPCODE_W'(16));
   assign op_legal = ((opcode >= OPCODE_W'(3)) && (opcode <= OPCODE_W'(11))) || op_hilo;

   assign state_dbg = state;

   // A shifted single bit stays one-hot; an index beyond NUM_REGS-1 shifts
   // out to all-zero instead of enabling an arbitrary register.
   function automatic logic [NUM_REGS-1:0] one_hot(input logic [REG_AW-1:0] idx);
      one_hot = NUM_REGS'(1) << idx;
   endfunction

   // ---------------------------------------------------------------- state
   always_ff @(posedge clock) begin
      if (!clear) begin
         state <= S_IDLE;
      end else begin
         case (state)
            S_IDLE: if (bus.start) state <= S_T0;
            S_T0:   state <= S_T1;
            S_T1:   if (bus.mem_ready) state <= S_T2;
            S_T2:   state <= S_T3;
            S_T3:   state <= op_legal ? S_T4 : S_IDLE;
            S_T4:   state <= S_T5;
            S_T5:   state <= op_hilo ? S_T6 : S_IDLE;
            S_T6:   state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

   // ---------------------------------------------------------------- strobes
   always_comb begin
      bus.pc_out    = 1'b0;
      bus.inc_pc    = 1'b0;
      bus.mar_in    = 1'b0;
      bus.pc_in     = 1'b0;
      bus.read      = 1'b0;
      bus.mdr_in    = 1'b0;
      bus.mdr_out   = 1'b0;
      bus.ir_in     = 1'b0;
      bus.y_in      = 1'b0;
      bus.z_in      = 1'b0;
      bus.zlow_out  = 1'b0;
      bus.zhigh_out = 1'b0;
      bus.hi_in     = 1'b0;
      bus.lo_in     = 1'b0;
      bus.reg_in    = '0;
      bus.reg_out   = '0;
      bus.alu_op    = '0;
      bus.done      = 1'b0;
      bus.err       = 1'b0;
      bus.busy      = (state != S_IDLE);

      case (state)
         S_T0: begin
            bus.pc_out = 1'b1;
            bus.mar_in = 1'b1;
            bus.inc_pc = 1'b1;
            bus.z_in   = 1'b1;
         end
         S_T1: begin
            bus.zlow_out = 1'b1;
            bus.read     = 1'b1;
            bus.mdr_in   = 1'b1;
            // Load PC only on the exit cycle so wait states cannot
            // re-increment it.
            bus.pc_in    = bus.mem_ready;
         end
         S_T2: begin
            bus.mdr_out = 1'b1;
            bus.ir_in   = 1'b1;
         end
         S_T3: begin
            if (op_legal) begin
               bus.reg_out = one_hot(rb);
               bus.y_in    = 1'b1;
            end else begin
               bus.done = 1'b1;
               bus.err  = 1'b1;
            end
         end
         S_T4: begin
            bus.reg_out = one_hot(rc);
            bus.alu_op  = opcode;
            bus.z_in    = 1'b1;
         end
         S_T5: begin
            bus.zlow_out = 1'b1;
            if (op_hilo) begin
               bus.lo_in = 1'b1;
            end else begin
               bus.reg_in = one_hot(ra);
               bus.done   = 1'b1;
            end
         end
         S_T6: begin
            bus.zhigh_out = 1'b1;
            bus.hi_in     = 1'b1;
            bus.done      = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_alu_instr_sequencer.sv
// -----------------------------------------------------------------------------
// tb_alu_instr_sequencer
//
// Purpose: self-checking bench for alu_instr_sequencer. A table of per-cycle
// records (inputs for the cycle plus the outputs expected during it) is
// applied back to back, followed by a hand-written sequence that measures
// start-to-done latency under varying memory wait states.
// -----------------------------------------------------------------------------
module tb_alu_instr_sequencer;

   // ------------------------------------------------------------ clock/reset
   logic       clock;
   logic       clear;
   logic [2:0] state_dbg;

   initial clock = 1'b0;
   always #5 clock = ~clock;

   alu_instr_sequencer_if #(.DATA_W(32), .NUM_REGS(16), .OPCODE_W(5)) bus ();

   alu_instr_sequencer #(.DATA_W(32), .NUM_REGS(16), .OPCODE_W(5)) dut (
      .clock     (clock),
      .clear     (clear),
      .bus       (bus),
      .state_dbg (state_dbg)
   );

   // Strobe bit positions in the packed strobe word.
   localparam logic [13:0] B_PCO  = 14'h2000;
   localparam logic [13:0] B_INC  = 14'h1000;
   localparam logic [13:0] B_MAR  = 14'h0800;
   localparam logic [13:0] B_PCI  = 14'h0400;
   localparam logic [13:0] B_RD   = 14'h0200;
   localparam logic [13:0] B_MDRI = 14'h0100;
   localparam logic [13:0] B_MDRO = 14'h0080;
   localparam logic [13:0] B_IRI  = 14'h0040;
   localparam logic [13:0] B_YI   = 14'h0020;
   localparam logic [13:0] B_ZI   = 14'h0010;
   localparam logic [13:0] B_ZLO  = 14'h0008;
   localparam logic [13:0] B_ZHO  = 14'h0004;
   localparam logic [13:0] B_HI   = 14'h0002;
   localparam logic [13:0] B_LO   = 14'h0001;

   localparam logic [31:0] IR_ADD = 32'h1C33_8000;  // ADD R8,R6,R7
   localparam logic [31:0] IR_MUL = 32'h781A_0000;  // MUL R3,R4
   localparam logic [31:0] IR_DIV = 32'h8000_0000;  // DIV R0,R0
   localparam logic [31:0] IR_O11 = 32'h5891_8000;  // op 11, ra=1 rb=2 rc=3

   typedef struct {
      string       name;
      bit          clr;
      bit          st;
      bit          mr;
      logic [31:0] ir;
      logic [2:0]  s;
      logic [13:0] strb;
      logic [15:0] rin;
      logic [15:0] rout;
      logic [4:0]  op;
      bit          dn;
      bit          er;
   } vec_t;

   vec_t vecs[$];
   logic [31:0] exp_q[$];
   int n_checks = 0;
   int n_pass   = 0;

   // ------------------------------------------------------------ scoreboard
   task automatic check(input string n, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp)
         $display("FAIL %s: got %h, expected %h", n, act, exp);
      else
         n_pass++;
   endtask

   function automatic logic [63:0] observed();
      return 64'({state_dbg,
                  bus.pc_out, bus.inc_pc, bus.mar_in, bus.pc_in, bus.read,
                  bus.mdr_in, bus.mdr_out, bus.ir_in, bus.y_in, bus.z_in,
                  bus.zlow_out, bus.zhigh_out, bus.hi_in, bus.lo_in,
                  bus.reg_in, bus.reg_out, bus.alu_op,
                  bus.busy, bus.done, bus.err});
   endfunction

   function automatic logic [63:0] expected(input vec_t v);
      return 64'({v.s, v.strb, v.rin, v.rout, v.op, (v.s != 3'd0), v.dn, v.er});
   endfunction

   // ------------------------------------------------------------ vector builders
   function automatic vec_t mk(input string n, input bit clr, input bit st, input bit mr,
                               input logic [31:0] i, input logic [2:0] s,
                               input logic [13:0] strb, input logic [15:0] rin,
                               input logic [15:0] rout, input logic [4:0] op,
                               input bit dn, input bit er);
      vec_t v;
      v.name = n; v.clr = clr; v.st = st; v.mr = mr; v.ir = i; v.s = s;
      v.strb = strb; v.rin = rin; v.rout = rout; v.op = op; v.dn = dn; v.er = er;
      return v;
   endfunction

   task automatic add_fetch(input string n, input logic [31:0] i, input int waits, input bit hold);
      vecs.push_back(mk({n, "_idle"}, 1, 1, 1, i, 3'd0, '0, '0, '0, '0, 0, 0));
      vecs.push_back(mk({n, "_t0"}, 1, hold, 1, i, 3'd1, B_PCO | B_INC | B_MAR | B_ZI, '0, '0, '0, 0, 0));
      for (int w = 0; w < waits; w++)
         vecs.push_back(mk({n, "_t1wait"}, 1, hold, 0, i, 3'd2, B_ZLO | B_RD | B_MDRI, '0, '0, '0, 0, 0));
      vecs.push_back(mk({n, "_t1"}, 1, hold, 1, i, 3'd2, B_ZLO | B_PCI | B_RD | B_MDRI, '0, '0, '0, 0, 0));
      vecs.push_back(mk({n, "_t2"}, 1, hold, 1, i, 3'd3, B_MDRO | B_IRI, '0, '0, '0, 0, 0));
   endtask

   task automatic add_instr(input string n, input logic [31:0] i, input logic [15:0] rout3,
                            input logic [15:0] rout4, input logic [4:0] op,
                            input logic [15:0] rin5, input bit hilo, input int waits,
                            input bit hold);
      add_fetch(n, i, waits, hold);
      vecs.push_back(mk({n, "_t3"}, 1, hold, 1, i, 3'd4, B_YI, '0, rout3, '0, 0, 0));
      vecs.push_back(mk({n, "_t4"}, 1, hold, 1, i, 3'd5, B_ZI, '0, rout4, op, 0, 0));
      if (hilo) begin
         vecs.push_back(mk({n, "_t5"}, 1, hold, 1, i, 3'd6, B_ZLO | B_LO, '0, '0, '0, 0, 0));
         vecs.push_back(mk({n, "_t6"}, 1, hold, 1, i, 3'd7, B_ZHO | B_HI, '0, '0, '0, 1, 0));
      end else begin
         vecs.push_back(mk({n, "_t5"}, 1, hold, 1, i, 3'd6, B_ZLO, rin5, '0, '0, 1, 0));
      end
   endtask

   task automatic add_illegal(input string n, input logic [31:0] i);
      add_fetch(n, i, 0, 0);
      vecs.push_back(mk({n, "_t3"}, 1, 0, 1, i, 3'd4, '0, '0, '0, '0, 1, 1));
   endtask

   // ------------------------------------------------------------ driver
   task automatic drive(input bit clr, input bit st, input bit mr, input logic [31:0] i);
      clear         = clr;
      bus.start     = st;
      bus.mem_ready = mr;
      bus.ir        = i;
   endtask

   // ------------------------------------------------------------ test
   initial begin
      int got;
      int n_wait;

      // Plain ALU op, then the same op with three memory wait states.
      add_instr("add",  IR_ADD, 16'h0040, 16'h0080, 5'd3,  16'h0100, 0, 0, 0);
      add_instr("addw", IR_ADD, 16'h0040, 16'h0080, 5'd3,  16'h0100, 0, 3, 0);
      // HI/LO writeback ops and the top legal ALU opcode.
      add_instr("mul",  IR_MUL, 16'h0008, 16'h0010, 5'd15, 16'h0000, 1, 0, 0);
      add_instr("div",  IR_DIV, 16'h0001, 16'h0001, 5'd16, 16'h0000, 1, 0, 0);
      add_instr("op11", IR_O11, 16'h0004, 16'h0008, 5'd11, 16'h0002, 0, 0, 0);
      // Illegal opcodes, including both neighbours of each legal range.
      add_illegal("ill31", 32'hF800_0000);
      add_illegal("ill12", 32'h6000_0000);
      add_illegal("ill2",  32'h1000_0000);
      add_illegal("ill17", 32'h8800_0000);
      // Reset during T4: next cycle IDLE with no done, then a fresh ADD.
      add_fetch("rst4", IR_ADD, 0, 0);
      vecs.push_back(mk("rst4_t3", 1, 0, 1, IR_ADD, 3'd4, B_YI, '0, 16'h0040, '0, 0, 0));
      vecs.push_back(mk("rst4_t4", 0, 0, 1, IR_ADD, 3'd5, B_ZI, '0, 16'h0080, 5'd3, 0, 0));
      add_instr("after_rst4", IR_ADD, 16'h0040, 16'h0080, 5'd3, 16'h0100, 0, 0, 0);
      // Reset during a T1 wait state.
      vecs.push_back(mk("rst1_idle", 1, 1, 1, IR_ADD, 3'd0, '0, '0, '0, '0, 0, 0));
      vecs.push_back(mk("rst1_t0", 1, 0, 0, IR_ADD, 3'd1, B_PCO | B_INC | B_MAR | B_ZI, '0, '0, '0, 0, 0));
      vecs.push_back(mk("rst1_t1wait", 0, 0, 0, IR_ADD, 3'd2, B_ZLO | B_RD | B_MDRI, '0, '0, '0, 0, 0));
      vecs.push_back(mk("rst1_after", 1, 0, 1, IR_ADD, 3'd0, '0, '0, '0, '0, 0, 0));
      // start held high across a whole instruction: one IDLE cycle, then T0.
      add_instr("lock1", IR_ADD, 16'h0040, 16'h0080, 5'd3, 16'h0100, 0, 0, 1);
      add_instr("lock2", IR_ADD, 16'h0040, 16'h0080, 5'd3, 16'h0100, 0, 0, 0);
      vecs.push_back(mk("final_idle", 1, 0, 1, IR_ADD, 3'd0, '0, '0, '0, '0, 0, 0));

      // Power-up state is undefined until the first clear edge.
      drive(0, 0, 1, '0);
      repeat (2) @(posedge clock);
      #1;

      foreach (vecs[k]) begin
         drive(vecs[k].clr, vecs[k].st, vecs[k].mr, vecs[k].ir);
         @(negedge clock);
         check(vecs[k].name, observed(), expected(vecs[k]));
         @(posedge clock);
         #1;
      end

      // Latency under random wait counts: ADD done arrives 6 + waits cycles
      // after the start edge.
      for (int t = 0; t < 4; t++) begin
         n_wait = $urandom_range(0, 4);
         exp_q.push_back(32'(6 + n_wait));
         drive(1, 1, 1, IR_ADD);
         @(posedge clock);
         #1;
         bus.start = 1'b0;
         got = -1;
         for (int c = 1; c <= 40; c++) begin
            bus.mem_ready = !((c >= 2) && (c < 2 + n_wait));
            @(negedge clock);
            if (bus.done) begin
               got = c;
               break;
            end
            @(posedge clock);
            #1;
         end
         check("latency", 64'(got), 64'(exp_q.pop_front()));
         @(posedge clock);
         #1;
         @(negedge clock);
         check("post_done_idle", 64'({bus.busy, bus.done, state_dbg}), 64'h0);
         @(posedge clock);
         #1;
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
